// File: rtl/placar_pkg.sv
// Shared constants and helpers for the scoreboard display front end.
package placar_pkg;

  localparam int DIVISOR_PADRAO = 50000;
  localparam int APAGADO_PADRAO = 2;

  // Width of an index able to address n items, never narrower than one bit.
  function automatic int largura_indice(input int n);
    if (n <= 2) begin
      return 1;
    end
    return $clog2(n);
  endfunction

endpackage

// File: rtl/decod_onehot.sv
// Index to one-hot decoder; indices outside 0..N-1 decode to all zeros.
module decod_onehot
  import placar_pkg::*;
#(
  parameter int N  = 4,
  parameter int IW = largura_indice(N)
) (
  input  logic [IW-1:0] idx,
  output logic [N-1:0]  onehot
);

  // One compare per output bit, so unused index codes light nothing.
  for (genvar gi = 0; gi < N; gi++) begin : g_bit
    assign onehot[gi] = (idx == IW'(gi));
  end

endmodule

// File: rtl/mux_varredura.sv
// Seven-segment scan multiplexer: one digit per slot, blanking at slot start,
// input word snapshotted once per frame so updates never tear.
module mux_varredura
  import placar_pkg::*;
#(
  parameter int CANAIS  = 4,
  parameter int LARGURA = 4,
  parameter int DIVISOR = DIVISOR_PADRAO,
  parameter int APAGADO = APAGADO_PADRAO,
  parameter int IW      = largura_indice(CANAIS)
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic                        habilita,
  input  logic [CANAIS*LARGURA-1:0]   dados,
  output logic [LARGURA-1:0]          saida,
  output logic [CANAIS-1:0]           anodo,
  output logic [IW-1:0]               indice,
  output logic                        fim_quadro
);

  localparam int CW = largura_indice(DIVISOR);
  localparam logic [CW-1:0] CNT_MAX = CW'(DIVISOR - 1);
  localparam logic [IW-1:0] IDX_MAX = IW'(CANAIS - 1);

  logic                      ativo_q, ativo_d;
  logic [CW-1:0]             cnt_q, cnt_d;
  logic [IW-1:0]             indice_q, indice_d;
  logic [CANAIS*LARGURA-1:0] sombra_q, sombra_d;
  logic                      fim_quadro_q, fim_quadro_d;

  logic [CANAIS-1:0]         onehot_w;
  logic                      aceso_w;

  // Next-state logic: idle start, prescaler/slot advance, frame wrap, disable.
  always_comb begin
    ativo_d      = ativo_q;
    cnt_d        = cnt_q;
    indice_d     = indice_q;
    sombra_d     = sombra_q;
    fim_quadro_d = 1'b0;
    if (!ativo_q) begin
      if (habilita) begin
        // Fresh start: no frame pulse, snapshot taken immediately.
        ativo_d  = 1'b1;
        cnt_d    = '0;
        indice_d = '0;
        sombra_d = dados;
      end
    end else if (!habilita) begin
      // Stop scanning; the snapshot is kept but will be replaced on restart.
      ativo_d  = 1'b0;
      cnt_d    = '0;
      indice_d = '0;
    end else if (cnt_q == CNT_MAX) begin
      cnt_d = '0;
      // Explicit compare so non-power-of-two digit counts wrap correctly.
      if (indice_q == IDX_MAX) begin
        indice_d     = '0;
        sombra_d     = dados;
        fim_quadro_d = 1'b1;
      end else begin
        indice_d = indice_q + 1'b1;
      end
    end else begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  // State registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      ativo_q      <= 1'b0;
      cnt_q        <= '0;
      indice_q     <= '0;
      sombra_q     <= '0;
      fim_quadro_q <= 1'b0;
    end else begin
      ativo_q      <= ativo_d;
      cnt_q        <= cnt_d;
      indice_q     <= indice_d;
      sombra_q     <= sombra_d;
      fim_quadro_q <= fim_quadro_d;
    end
  end

  // Blanking window: with no blank cycles the anode is lit for the whole slot.
  if (APAGADO == 0) begin : g_sem_apagado
    assign aceso_w = 1'b1;
  end else begin : g_com_apagado
    assign aceso_w = (cnt_q >= CW'(APAGADO));
  end

  decod_onehot #(
    .N  (CANAIS),
    .IW (IW)
  ) u_decod (
    .idx    (indice_q),
    .onehot (onehot_w)
  );

  // Output decode from registers only; nothing from the inputs reaches here.
  always_comb begin
    saida = '0;
    anodo = '0;
    if (ativo_q) begin
      saida = sombra_q[indice_q*LARGURA +: LARGURA];
      if (aceso_w) begin
        anodo = onehot_w;
      end
    end
  end

  assign indice     = indice_q;
  assign fim_quadro = fim_quadro_q;

endmodule

// File: tb/tb_mux_varredura.sv
// Directed table-driven bench for mux_varredura plus two parameter variants.
module tb_mux_varredura;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        habilita;
  logic [15:0] dados;
  logic [15:0] dados_v = 16'h4321;

  logic [3:0] saida, anodo;
  logic [1:0] indice;
  logic       fim_quadro;

  logic [3:0] saida_b;
  logic [2:0] anodo_b;
  logic [1:0] indice_b;
  logic       fim_b;

  logic [3:0] saida_c, anodo_c;
  logic [1:0] indice_c;
  logic       fim_c;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  mux_varredura #(.CANAIS(4), .LARGURA(4), .DIVISOR(4), .APAGADO(1)) dut (
    .clk(clk), .rst_n(rst_n), .habilita(habilita), .dados(dados),
    .saida(saida), .anodo(anodo), .indice(indice), .fim_quadro(fim_quadro)
  );

  mux_varredura #(.CANAIS(3), .LARGURA(4), .DIVISOR(4), .APAGADO(0)) dut_b (
    .clk(clk), .rst_n(rst_n), .habilita(habilita), .dados(dados_v[11:0]),
    .saida(saida_b), .anodo(anodo_b), .indice(indice_b), .fim_quadro(fim_b)
  );

  mux_varredura #(.CANAIS(4), .LARGURA(4), .DIVISOR(2), .APAGADO(1)) dut_c (
    .clk(clk), .rst_n(rst_n), .habilita(habilita), .dados(dados_v),
    .saida(saida_c), .anodo(anodo_c), .indice(indice_c), .fim_quadro(fim_c)
  );

  typedef struct {
    logic        hab;
    logic [15:0] dados;
    logic [3:0]  an;
    logic [3:0]  sa;
    logic [1:0]  ix;
    logic        fim;
  } vec_t;

  vec_t tab[$];

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", nm, act, exp);
    end
  endtask

  task automatic push(input logic h, input logic [15:0] d, input logic [3:0] an,
                      input logic [3:0] sa, input logic [1:0] ix, input logic fim);
    vec_t v;
    v.hab = h; v.dados = d; v.an = an; v.sa = sa; v.ix = ix; v.fim = fim;
    tab.push_back(v);
  endtask

  // Four cycles per slot: one blank cycle, then the slot's anode lit.
  task automatic push_slots(input logic [15:0] d_in, input logic [15:0] shown,
                            input int s0, input int s1, input bit fim_first);
    for (int s = s0; s <= s1; s++) begin
      for (int c = 0; c < 4; c++) begin
        logic [3:0] an;
        an = (c >= 1) ? 4'(1 << s) : 4'd0;
        push(1'b1, d_in, an, shown[s*4 +: 4], 2'(s), (fim_first && s == s0 && c == 0));
      end
    end
  endtask

  initial begin
    int cyc;
    int sb, sc, cc;
    bit achou;

    // ---- reset held with enable high ----
    rst_n = 1'b0; habilita = 1'b1; dados = 16'h4321;
    for (int i = 0; i < 3; i++) begin
      tick();
      $display("reset cycle %0d: an=%b sa=%0h ix=%0d fim=%0b", i, anodo, saida, indice, fim_quadro);
      chk($sformatf("rst%0d_anodo", i), anodo, 0);
      chk($sformatf("rst%0d_saida", i), saida, 0);
      chk($sformatf("rst%0d_indice", i), indice, 0);
      chk($sformatf("rst%0d_fim", i), fim_quadro, 0);
      chk($sformatf("rst%0d_anodo_b", i), anodo_b, 0);
      chk($sformatf("rst%0d_anodo_c", i), anodo_c, 0);
    end

    // ---- build the table ----
    // First frame shows 4321; dados switches to 8765 during slot 1.
    push_slots(16'h8765, 16'h4321, 0, 3, 1'b0);
    for (int i = 0; i < 5; i++) tab[i].dados = 16'h4321;
    // Second frame shows 8765, disabled in slot 2.
    push_slots(16'h8765, 16'h8765, 0, 1, 1'b1);
    push(1'b1, 16'h8765, 4'b0000, 4'h7, 2'd2, 1'b0);
    push(1'b1, 16'h8765, 4'b0100, 4'h7, 2'd2, 1'b0);
    push(1'b0, 16'h8765, 4'b0000, 4'h0, 2'd0, 1'b0);
    // Restart with a new snapshot, no pulse on start, pulse after a full frame.
    push_slots(16'hABCD, 16'hABCD, 0, 3, 1'b0);
    push(1'b1, 16'hABCD, 4'b0000, 4'hD, 2'd0, 1'b1);

    // ---- apply table; release reset with the first entry ----
    rst_n = 1'b1;
    for (int i = 0; i < tab.size(); i++) begin
      habilita = tab[i].hab;
      dados    = tab[i].dados;
      tick();
      cyc = i + 1;
      $display("cycle %0d: hab=%0b dados=%h an=%b sa=%0h ix=%0d fim=%0b", cyc,
               tab[i].hab, tab[i].dados, anodo, saida, indice, fim_quadro);
      chk($sformatf("c%0d_anodo", cyc), anodo, tab[i].an);
      chk($sformatf("c%0d_saida", cyc), saida, tab[i].sa);
      chk($sformatf("c%0d_indice", cyc), indice, tab[i].ix);
      chk($sformatf("c%0d_fim", cyc), fim_quadro, tab[i].fim);
      if (cyc <= 24) begin
        // 3 digits, 4-cycle slots, no blanking.
        sb = ((cyc - 1) / 4) % 3;
        chk($sformatf("c%0d_b_indice", cyc), indice_b, sb);
        chk($sformatf("c%0d_b_anodo", cyc), anodo_b, 1 << sb);
        chk($sformatf("c%0d_b_saida", cyc), saida_b, sb + 1);
        chk($sformatf("c%0d_b_fim", cyc), fim_b, (cyc == 13) ? 1 : 0);
        // 4 digits, 2-cycle slots, one blank cycle.
        sc = ((cyc - 1) / 2) % 4;
        cc = (cyc - 1) % 2;
        chk($sformatf("c%0d_c_indice", cyc), indice_c, sc);
        chk($sformatf("c%0d_c_anodo", cyc), anodo_c, (cc >= 1) ? (1 << sc) : 0);
        chk($sformatf("c%0d_c_saida", cyc), saida_c, sc + 1);
        chk($sformatf("c%0d_c_fim", cyc), fim_c, (cyc == 9 || cyc == 17) ? 1 : 0);
      end
    end

    // ---- reset mid-frame during slot 3 ----
    achou = 1'b0;
    for (int i = 0; i < 40 && !achou; i++) begin
      if (indice == 2'd3) achou = 1'b1;
      else tick();
    end
    chk("wait_slot3", achou, 1'b1);
    rst_n = 1'b0;
    tick();
    $display("mid reset: an=%b sa=%0h ix=%0d fim=%0b", anodo, saida, indice, fim_quadro);
    chk("mrst_anodo", anodo, 0);
    chk("mrst_saida", saida, 0);
    chk("mrst_indice", indice, 0);
    chk("mrst_fim", fim_quadro, 0);

    rst_n = 1'b1; habilita = 1'b1; dados = 16'h1357;
    tick();
    $display("post reset start: an=%b sa=%0h ix=%0d fim=%0b", anodo, saida, indice, fim_quadro);
    chk("prst0_anodo", anodo, 4'b0000);
    chk("prst0_saida", saida, 4'h7);
    chk("prst0_indice", indice, 0);
    chk("prst0_fim", fim_quadro, 0);
    tick();
    $display("post reset lit: an=%b sa=%0h ix=%0d", anodo, saida, indice);
    chk("prst1_anodo", anodo, 4'b0001);
    chk("prst1_saida", saida, 4'h7);
    tick(); tick(); tick();
    $display("post reset slot1: an=%b sa=%0h ix=%0d", anodo, saida, indice);
    chk("prst4_indice", indice, 1);
    chk("prst4_saida", saida, 4'h5);
    chk("prst4_anodo", anodo, 4'b0000);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/mux_varredura.md
# mux_varredura

Parametrised display-scan multiplexer for the scoreboard's seven-segment front end. It takes `CANAIS` digit codes of `LARGURA` bits and time-multiplexes them onto one shared digit bus. A free-running prescaler sets the dwell time on each digit, and a one-hot anode enable follows the selected digit, with a programmable blanking window at the start of each slot to suppress ghosting. The input word is snapshotted once per frame, so a score update never tears across a frame. It feeds the BCD-to-7-segment decoder and the board's anode drivers directly.

## Interface
- `CANAIS`, 4: number of digits scanned; ≥ 2, any value (power of two not required).
- `LARGURA`, 4: bits per digit code.
- `DIVISOR`, 50000: clock cycles per digit slot; ≥ 2.
- `APAGADO`, 2: blank cycles at the start of each slot; 0 ≤ `APAGADO` < `DIVISOR`.
- `clk`  in  1  single system clock; all state updates on the rising edge.
- `rst_n`  in  1  synchronous, active-low reset.
- `habilita`  in  1  scan enable.
- `dados`  in  `CANAIS*LARGURA`  packed digit codes; digit i is `dados[i*LARGURA +: LARGURA]`.
- `saida`  out  `LARGURA`  code of the currently selected digit.
- `anodo`  out  `CANAIS`  one-hot digit enable, active-high.
- `indice`  out  `IW = max(1, clog2(CANAIS))`  currently selected slot.
- `fim_quadro`  out  1  one-cycle pulse marking the first cycle of each new frame.

## Operation
- State registers:
  - `ativo` flag.
  - Prescaler `cnt`, width `clog2(DIVISOR)`.
  - `indice`.
  - Shadow register `sombra`, `CANAIS*LARGURA` bits.
  - `fim_quadro` register.
- Reset (`rst_n` = 0 at an edge) sets `ativo` = 0, `cnt` = 0, `indice` = 0, `sombra` = 0 and `fim_quadro` = 0. Reset has priority over every other input.
- Idle (`ativo` = 0):
  - If `habilita` = 1, the next edge sets `ativo` = 1, clears `cnt` and `indice`, and loads `sombra` <= `dados`.
  - No `fim_quadro` pulse is generated on this start.
- Running (`ativo` = 1, `habilita` = 1):
  - If `cnt` < `DIVISOR`-1, then `cnt`++.
  - If `cnt` = `DIVISOR`-1, then `cnt` <= 0 and `indice` advances.
  - When `indice` = `CANAIS`-1 at that wrap point: `indice` <= 0, `sombra` <= `dados`, and `fim_quadro` <= 1.
  - `fim_quadro` is 0 at every other edge.
- Disable: `habilita` = 0 while running makes the next edge set `ativo` = 0, `cnt` = 0 and `indice` = 0. `sombra` holds its value.
- Outputs are combinational decode of registers only; there is no path from `dados` or `habilita` to any output.
  - `saida` = `ativo` ? `sombra[indice*LARGURA +: LARGURA]` : 0.
  - `anodo` = (`ativo` && `cnt` ≥ `APAGADO`) ? onehot(`indice`) : 0.
- `indice` never reaches a value ≥ `CANAIS`. For non-power-of-two `CANAIS`, the wrap is an explicit compare, not natural overflow.

## Timing
- Reset values: `saida` = 0, `anodo` = 0, `indice` = 0, `fim_quadro` = 0.
- Latency:
  - `habilita` rising at edge k gives `ativo` = 1 after edge k.
  - The first lit anode appears `APAGADO` cycles later.
- Each slot lasts exactly `DIVISOR` cycles. The anode is dark for the first `APAGADO` cycles of the slot and lit for `DIVISOR`-`APAGADO` cycles.
- A frame is `CANAIS*DIVISOR` cycles. `fim_quadro` is high for exactly the first cycle of every frame after the first.
- `dados` is sampled only at frame start, so changes mid-frame take effect at the next frame.
- If `habilita` falls and rises again in consecutive cycles, the block restarts from slot 0 with a fresh snapshot. There is no partial-frame resume.
- A reset mid-frame produces all outputs at their reset values after the reset edge.

## Structure
- Shared package `placar_pkg`:
  - Index-width function `largura_indice(n)`, returning max(1, clog2(n)).
  - Default constants `DIVISOR_PADRAO` = 50000 and `APAGADO_PADRAO` = 2.
- Sub-module `decod_onehot`, parameter `N`: `IW`-bit index in, N-bit one-hot out, all zeros for out-of-range indices. It is instantiated once for `anodo`.
- The digit select is an indexed part-select inside `mux_varredura`; it does not need a separate module.

## Test plan
Default bench parameters: `CANAIS` = 4, `LARGURA` = 4, `DIVISOR` = 4, `APAGADO` = 1.
- **Reset:** hold `rst_n` = 0 for 3 cycles with `habilita` = 1 and `dados` = 16'h4321 -> `anodo` = 0, `saida` = 0, `indice` = 0 and `fim_quadro` = 0 throughout.
- **Start and first frame:** `dados` = 16'h4321, raise `habilita` at edge 0 ->
  - Cycle 1: `anodo` = 0000 with `saida` = 1.
  - Cycles 2–4: `anodo` = 0001, `saida` = 1.
  - Cycles 5–8: slot 1, `saida` = 2, `anodo` = 0010 after one blank cycle.
  - Remaining slots follow for `saida` = 3 (`anodo` = 0100) and `saida` = 4 (`anodo` = 1000).
  - `fim_quadro` = 1 only in cycle 17.
- **Tear-free update:** change `dados` to 16'h8765 during slot 1 -> slots 2 and 3 still show 3 and 4; the next frame shows 5, 6, 7, 8.
- **Disable mid-frame:** drop `habilita` in slot 2 -> next cycle `anodo` = 0, `saida` = 0, `indice` = 0. Re-raise -> restart at slot 0 with a new snapshot and no `fim_quadro` pulse.
- **Reset mid-frame:** assert `rst_n` = 0 during slot 3 -> all outputs reach their reset values after the edge. Release with `habilita` = 1 -> normal start from slot 0.
- **Parameter variants:**
  - `CANAIS` = 3, `APAGADO` = 0: `indice` sequence 0, 1, 2, 0, never 3; the anode is lit in every cycle of the slot.
  - `DIVISOR` = 2: slot length is exactly 2 cycles.
